// File: rtl/hdmi_clk_pkg.sv
// Shared types for the HDMI PLL clock supervisor: FSM states and sticky
// fault codes reported to software.
package hdmi_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_LOCK    = 2'b01;
  localparam logic [1:0] FLT_PERIOD  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT = 2'b11;

endpackage

// File: rtl/hdmi_sync_edge.sv
// Two-flop synchroniser for an asynchronous PLL signal, plus a rising-edge
// pulse derived from one extra history flop.
module hdmi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchroniser chain and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign q    = sync_r;
  assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/hdmi_clk_supervisor.sv
// Holds the HDMI pipeline in reset until the PLL has been locked long enough,
// and pulls it back into reset on lock loss or a bad/dead CLKOS2 heartbeat.
module hdmi_clk_supervisor
  import hdmi_clk_pkg::*;
#(
  parameter int STABLE_CYCLES = 4800,
  parameter int TICK_MIN      = 900,
  parameter int TICK_MAX      = 1100,
  parameter int TICK_TIMEOUT  = 2047,
  parameter int TICK_W        = 12,
  parameter int MIN_RST       = 16,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              pll_tick,
  input  logic              clr_status,
  output logic              pix_rst_n,
  output logic              running,
  output logic [1:0]        fault_code,
  output logic [CNT_W-1:0]  loss_cnt,
  output logic [TICK_W-1:0] tick_period
);

  localparam int SCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int FCNT_W = (MIN_RST > 1) ? $clog2(MIN_RST) : 1;
  localparam logic [SCNT_W-1:0] STABLE_LAST  = SCNT_W'(STABLE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FAULT_LAST   = FCNT_W'(MIN_RST - 1);
  localparam logic [TICK_W-1:0] TICK_MIN_V   = TICK_W'(TICK_MIN);
  localparam logic [TICK_W-1:0] TICK_MAX_V   = TICK_W'(TICK_MAX);
  localparam logic [TICK_W-1:0] TICK_TOUT_V  = TICK_W'(TICK_TIMEOUT);

  logic              locked_s;
  logic              lock_edge_s;
  logic              tick_s;
  logic              tick_edge_s;
  logic              unused_sync_s;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [SCNT_W-1:0] scnt_r;
  logic [SCNT_W-1:0] scnt_nxt_s;
  logic [FCNT_W-1:0] fcnt_r;
  logic [FCNT_W-1:0] fcnt_nxt_s;
  logic [TICK_W-1:0] pcnt_r;
  logic [TICK_W-1:0] pcnt_inc_s;
  logic              first_edge_r;
  logic [TICK_W-1:0] tick_period_r;
  logic              timeout_s;
  logic              period_bad_s;
  logic              stab_entry_s;
  logic              fault_set_s;
  logic [1:0]        fault_new_s;
  logic [1:0]        fault_code_r;
  logic [CNT_W-1:0]  loss_cnt_r;
  logic              pix_rst_n_r;
  logic              running_r;

  hdmi_sync_edge u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s),
    .rise  (lock_edge_s)
  );

  hdmi_sync_edge u_tick_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_tick),
    .q     (tick_s),
    .rise  (tick_edge_s)
  );

  assign unused_sync_s = lock_edge_s ^ tick_s;

  // A tick edge landing on the timeout cycle is a valid heartbeat, not a timeout.
  assign pcnt_inc_s   = pcnt_r + TICK_W'(1);
  assign timeout_s    = (pcnt_r == TICK_TOUT_V) && !tick_edge_s;
  assign period_bad_s = tick_edge_s && !first_edge_r &&
                        ((pcnt_inc_s < TICK_MIN_V) || (pcnt_inc_s > TICK_MAX_V));
  assign stab_entry_s = (state_r == WAIT_LOCK) && locked_s;

  // next-state, counter and fault-recording decode
  always_comb begin
    state_nxt_s = state_r;
    scnt_nxt_s  = '0;
    fcnt_nxt_s  = '0;
    fault_set_s = 1'b0;
    fault_new_s = FLT_NONE;
    case (state_r)
      WAIT_LOCK: begin
        if (locked_s) state_nxt_s = STABILIZE;
        else          state_nxt_s = WAIT_LOCK;
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (scnt_r == STABLE_LAST) begin
          state_nxt_s = RUN;
        end else begin
          scnt_nxt_s = scnt_r + SCNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt_s = FAULT;
          fault_set_s = 1'b1;
          fault_new_s = FLT_LOCK;
        end else if (timeout_s) begin
          state_nxt_s = FAULT;
          fault_set_s = 1'b1;
          fault_new_s = FLT_TIMEOUT;
        end else if (period_bad_s) begin
          state_nxt_s = FAULT;
          fault_set_s = 1'b1;
          fault_new_s = FLT_PERIOD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FAULT: begin
        if (fcnt_r == FAULT_LAST) state_nxt_s = WAIT_LOCK;
        else                      fcnt_nxt_s  = fcnt_r + FCNT_W'(1);
      end
      default: state_nxt_s = WAIT_LOCK;
    endcase
  end

  // state, counters and registered reset outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= WAIT_LOCK;
      scnt_r      <= '0;
      fcnt_r      <= '0;
      pix_rst_n_r <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      scnt_r      <= scnt_nxt_s;
      fcnt_r      <= fcnt_nxt_s;
      pix_rst_n_r <= (state_nxt_s == RUN);
      running_r   <= (state_nxt_s == RUN);
    end
  end

  // heartbeat period measurement; a fresh lock attempt restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r        <= '0;
      first_edge_r  <= 1'b1;
      tick_period_r <= '0;
    end else begin
      if (tick_edge_s) tick_period_r <= pcnt_inc_s;
      else             tick_period_r <= tick_period_r;
      if (stab_entry_s) begin
        pcnt_r       <= '0;
        first_edge_r <= 1'b1;
      end else if (tick_edge_s) begin
        pcnt_r       <= '0;
        first_edge_r <= 1'b0;
      end else if (pcnt_r != TICK_TOUT_V) begin
        pcnt_r       <= pcnt_inc_s;
        first_edge_r <= first_edge_r;
      end else begin
        pcnt_r       <= pcnt_r;
        first_edge_r <= first_edge_r;
      end
    end
  end

  // sticky status; a fault recorded alongside clr_status takes precedence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_code_r <= FLT_NONE;
      loss_cnt_r   <= '0;
    end else if (fault_set_s) begin
      fault_code_r <= fault_new_s;
      if (clr_status)              loss_cnt_r <= CNT_W'(1);
      else if (loss_cnt_r != '1)   loss_cnt_r <= loss_cnt_r + CNT_W'(1);
      else                         loss_cnt_r <= loss_cnt_r;
    end else if (clr_status) begin
      fault_code_r <= FLT_NONE;
      loss_cnt_r   <= '0;
    end else begin
      fault_code_r <= fault_code_r;
      loss_cnt_r   <= loss_cnt_r;
    end
  end

  assign pix_rst_n   = pix_rst_n_r;
  assign running     = running_r;
  assign fault_code  = fault_code_r;
  assign loss_cnt    = loss_cnt_r;
  assign tick_period = tick_period_r;

endmodule

// File: tb/tb_hdmi_clk_supervisor.sv
// Directed bench for hdmi_clk_supervisor with a short stabilise window and
// fault hold; expected values are derived from pin-to-register timing.
module tb_hdmi_clk_supervisor;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_tick;
  logic       clr_status;
  logic       pix_rst_n;
  logic       running;
  logic [1:0] fault_code;
  logic [7:0] loss_cnt;
  logic [11:0] tick_period;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_phase = 0;
  int tick_per   = 1000;
  int tick_en    = 1;
  int last_rise  = 0;

  hdmi_clk_supervisor #(
    .STABLE_CYCLES (16),
    .MIN_RST       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_tick    (pll_tick),
    .clr_status  (clr_status),
    .pix_rst_n   (pix_rst_n),
    .running     (running),
    .fault_code  (fault_code),
    .loss_cnt    (loss_cnt),
    .tick_period (tick_period)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // heartbeat source: rises every tick_per cycles, driven just after negedge
  initial begin
    pll_tick = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (tick_en != 0) begin
        if (tick_phase == 0) begin
          pll_tick  = 1'b1;
          last_rise = cyc;
        end else if (tick_phase == 4) begin
          pll_tick = 1'b0;
        end
        tick_phase = (tick_phase >= tick_per - 1) ? 0 : tick_phase + 1;
      end else begin
        pll_tick   = 1'b0;
        tick_phase = 0;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_rise();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick_phase != 1 && n < 3000);
    check("rise_wait", tick_phase, 1);
  endtask

  task automatic wait_running();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (running !== 1'b1 && n < 200);
    check("run_wait", running, 1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  initial begin
    int c;
    int t;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    clr_status = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pix", pix_rst_n, 0);
    check("rst_running", running, 0);
    check("rst_fault", fault_code, 0);
    check("rst_loss", loss_cnt, 0);
    check("rst_period", tick_period, 0);
    rst_n = 1'b1;

    // clean lock: release 19 cycles after the lock edge
    @(negedge clk);
    c = cyc;
    pll_locked = 1'b1;
    wait_cyc(c + 18);
    check("lock_pix_early", pix_rst_n, 0);
    wait_cyc(c + 19);
    check("lock_pix_rel", pix_rst_n, 1);
    check("lock_running", running, 1);
    check("lock_fault", fault_code, 0);
    wait_rise();
    wait_rise();
    t = last_rise;
    wait_cyc(t + 4);
    check("lock_period", tick_period, 1000);
    check("lock_fault2", fault_code, 0);

    // asynchronous reset in RUN
    @(negedge clk);
    rst_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    check("arst_pix", pix_rst_n, 0);
    check("arst_running", running, 0);
    check("arst_period", tick_period, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // one-cycle lock glitch inside STABILIZE restarts the window, no fault
    @(negedge clk);
    c = cyc;
    pll_locked = 1'b1;
    wait_cyc(c + 8);
    pll_locked = 1'b0;
    wait_cyc(c + 9);
    pll_locked = 1'b1;
    wait_cyc(c + 19);
    check("glitch_pix_19", pix_rst_n, 0);
    wait_cyc(c + 27);
    check("glitch_pix_27", pix_rst_n, 0);
    check("glitch_fault", fault_code, 0);
    check("glitch_loss", loss_cnt, 0);
    wait_cyc(c + 28);
    check("glitch_pix_rel", pix_rst_n, 1);

    // lock lost in RUN; lock returns during FAULT, hold still lasts 4 cycles
    @(negedge clk);
    c = cyc;
    pll_locked = 1'b0;
    wait_cyc(c + 1);
    pll_locked = 1'b1;
    wait_cyc(c + 2);
    check("loss_pix_pre", pix_rst_n, 1);
    wait_cyc(c + 3);
    check("loss_pix", pix_rst_n, 0);
    check("loss_running", running, 0);
    check("loss_fault", fault_code, 1);
    check("loss_cnt1", loss_cnt, 1);
    wait_cyc(c + 23);
    check("loss_hold", pix_rst_n, 0);
    wait_cyc(c + 24);
    check("relock_pix", pix_rst_n, 1);
    check("relock_sticky", fault_code, 1);
    pulse_clr();
    check("clr_fault", fault_code, 0);
    check("clr_loss", loss_cnt, 0);

    // short heartbeat period
    wait_rise();
    wait_rise();
    t = last_rise;
    tick_per = 850;
    wait_cyc(t + 852);
    check("p850_pre_run", running, 1);
    check("p850_pre_fault", fault_code, 0);
    wait_cyc(t + 853);
    tick_per = 1000;
    check("p850_fault", fault_code, 2);
    check("p850_period", tick_period, 850);
    check("p850_pix", pix_rst_n, 0);
    check("p850_loss", loss_cnt, 1);

    // long heartbeat period
    wait_running();
    pulse_clr();
    wait_rise();
    wait_rise();
    t = last_rise;
    tick_per = 1200;
    wait_cyc(t + 1202);
    check("p1200_pre_run", running, 1);
    check("p1200_pre_fault", fault_code, 0);
    wait_cyc(t + 1203);
    tick_per = 1000;
    check("p1200_fault", fault_code, 2);
    check("p1200_period", tick_period, 1200);
    check("p1200_running", running, 0);

    // heartbeat stops: timeout when the counter reaches 2047
    wait_running();
    pulse_clr();
    wait_rise();
    wait_rise();
    t = last_rise;
    tick_en = 0;
    wait_cyc(t + 2050);
    check("tout_pre_fault", fault_code, 0);
    check("tout_pre_run", running, 1);
    wait_cyc(t + 2051);
    check("tout_fault", fault_code, 3);
    check("tout_loss", loss_cnt, 1);
    check("tout_pix", pix_rst_n, 0);
    tick_en = 1;

    // loss counter saturation
    wait_running();
    pulse_clr();
    for (int i = 1; i <= 256; i++) begin
      wait_running();
      c = cyc;
      pll_locked = 1'b0;
      wait_cyc(c + 1);
      pll_locked = 1'b1;
      wait_cyc(c + 3);
      if (i == 255) check("sat_255", loss_cnt, 255);
      if (i == 256) check("sat_hold", loss_cnt, 255);
    end

    // clear coincident with a new fault: fault wins, count restarts at 1
    wait_running();
    c = cyc;
    pll_locked = 1'b0;
    wait_cyc(c + 1);
    pll_locked = 1'b1;
    wait_cyc(c + 2);
    clr_status = 1'b1;
    wait_cyc(c + 3);
    clr_status = 1'b0;
    check("clrhit_fault", fault_code, 1);
    check("clrhit_loss", loss_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
